alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execution-stage ALU for the MIPS core that consumes the 3-bit `ALU_control` code produced by the ALU control decoder. It performs and/or/add/sub in one registered cycle and mul through a 32-iteration shift-add sequencer. A start/busy/done handshake plus a `stall` output lets the datapath freeze PC and pipeline registers while a multiply is in flight.

## Interface
- `WIDTH`, default 32: operand and result width. The multiply iteration count equals `WIDTH`.
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-high reset.
- `start`  input  1: operation request, sampled at the rising edge in IDLE only.
- `ALU_control`  input  3: 000 and, 001 or, 010 add, 011 mul, 110 sub. Any other code yields a zero result.
- `A`  input  WIDTH: operand A (rs). Sampled with `start`.
- `B`  input  WIDTH: operand B (rt or immediate). Sampled with `start`.
- `result`  output  WIDTH: registered result. Holds its value until the next completion.
- `zero`  output  1: registered flag, equal to (`result` == 0).
- `done`  output  1: one-cycle pulse when `result` updates.
- `busy`  output  1: high while a multiply sequence is running.
- `stall`  output  1: combinational, equal to `busy` | (`start` & `ALU_control`==011 & state==IDLE).

## Operation
- Reset is asynchronous and active-high.
  - Outputs: `result`=0, `zero`=1, `done`=0, `busy`=0.
  - Internal state: state=IDLE, counter=0, accumulator=0.
  - Reset asserted mid-multiply aborts the sequence immediately; no `done` is issued.
- States:
  - IDLE: accepts `start`.
  - MUL: iterates the multiply.
- IDLE, `start`=1, code not 011:
  - Compute the selected function of A and B.
  - Register it into `result` and `zero`; pulse `done`. State stays IDLE.
- IDLE, `start`=1, code 011:
  - Load multiplicand=A, multiplier=B, acc=0, count=0.
  - Go to MUL and set `busy`=1.
- MUL, each cycle:
  - If multiplier[0]=1, then acc = acc + multiplicand, mod 2^WIDTH.
  - Shift multiplicand left by 1; shift multiplier right by 1; count = count + 1.
  - On the iteration where count==WIDTH-1:
    - Write the final acc into `result` and `zero`; pulse `done`.
    - Clear `busy` and return to IDLE.
- Arithmetic rules:
  - All arithmetic wraps mod 2^WIDTH and uses unsigned bit patterns.
  - mul returns the low WIDTH bits of the product, which is also correct for two's-complement operands.
  - No overflow flag is produced.
  - sub is A + ~B + 1.
- `start` while `busy`=1 is ignored; operands are not resampled. The datapath must hold `start` and operands while `stall`=1.
- The sequence length is fixed. There is no early termination, even when the multiplier is 0.
- Undefined codes (100, 101, 111) behave as a single-cycle op with `result`=0 and `zero`=1.

## Timing
- Edge numbering: E0 is the edge where `start` is accepted.
- Single-cycle ops:
  - `result`, `zero` and `done` are valid in the cycle after E0, i.e. 1-cycle latency.
  - Back-to-back `start` every cycle is sustained, giving throughput 1/cycle.
- mul:
  - Iterations occur at edges E1..E32 (for WIDTH=32).
  - `busy` is high in the cycles following E0 through E31.
  - `result` and `done` are valid in the cycle after E32, i.e. latency WIDTH+1 = 33 cycles.
  - `busy`=0 and `done`=1 hold in the same cycle.
- Simultaneous events:
  - A `start` presented in the `done` cycle is accepted at the next edge, since the state is already IDLE. There is no dead cycle between ops.
- `stall`:
  - Rises combinationally in the cycle `start` with mul is presented.
  - Stays high through the last MUL cycle (before E32).
  - Low in the `done` cycle.
- `done` is never high for two consecutive cycles from a single op. Consecutive single-cycle ops give consecutive pulses, one per op.

## Test plan
- Reset release, then `start` with and, A=0xF0F0F0F0, B=0xFF00FF00 -> next cycle `result`=0xF000F000, `zero`=0, `done`=1 for one cycle.
- Wrap-around checks:
  - add A=0xFFFFFFFF, B=1 -> `result`=0, `zero`=1.
  - sub A=5, B=7 -> `result`=0xFFFFFFFE.
- mul A=7, B=6 at E0:
  - `stall`=1 in the start cycle.
  - `busy`=1 for 32 cycles.
  - `done` in the cycle after E32 with `result`=42, `busy`=0.
- Overflow and signed cases:
  - mul A=0x00010000, B=0x00010000 -> `result`=0, `zero`=1.
  - mul A=0xFFFFFFFF (-1), B=3 -> `result`=0xFFFFFFFD.
- Start while busy:
  - During a mul, pulse `start` with add A=1, B=1 at cycle 10 -> ignored.
  - Final `result` is the mul product.
  - A subsequent add issued in the `done` cycle yields 2 one cycle later.
- Reset mid-operation:
  - Assert `reset` asynchronously at cycle 15 of a mul -> outputs return immediately to `result`=0, `zero`=1, `busy`=0, `done`=0.
  - No `done` follows after release.
  - An undefined code 111 then yields `result`=0, `done`=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle and/or/add/sub plus a WIDTH-iteration shift-add multiply
// with start/busy/done handshake and a combinational stall for the pipeline.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALU_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             done,
  output logic             busy,
  output logic             stall
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state;
  logic [CntW-1:0]  count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    alu_res = '0;
    case (ALU_control)
      3'b000:  alu_res = A & B;
      3'b001:  alu_res = A | B;
      3'b010:  alu_res = A + B;
      3'b110:  alu_res = A + ~B + 1'b1;
      default: alu_res = '0;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  assign stall = busy | (start & (ALU_control == 3'b011) & (state == StIdle));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= StIdle;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            if (ALU_control == 3'b011) begin
              mcand  <= A;
              mplier <= B;
              acc    <= '0;
              count  <= '0;
              busy   <= 1'b1;
              state  <= StMul;
            end else begin
              result <= alu_res;
              zero   <= (alu_res == '0);
              done   <= 1'b1;
            end
          end
        end
        StMul: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // Fixed-length sequence: finish on the last iteration regardless of operands.
          if (count == LastCnt) begin
            result <= acc_next;
            zero   <= (acc_next == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: expected results are queued at issue and popped on done.
module tb_alu_exec_unit;
  localparam int unsigned WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  ALU_control;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        zero;
  logic        done;
  logic        busy;
  logic        stall;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  logic [2:0]  sc_op[8];
  logic [31:0] sc_a[8];
  logic [31:0] sc_b[8];

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALU_control(ALU_control),
    .A          (A),
    .B          (B),
    .result     (result),
    .zero       (zero),
    .done       (done),
    .busy       (busy),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a * b;
      3'b110:  return a - b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hDEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ALU_control = 3'b000; A = '0; B = '0;
    repeat (2) @(negedge clk);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_single_cycle();
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b1; ALU_control = sc_op[i]; A = sc_a[i]; B = sc_b[i];
      exp_q.push_back(model(sc_op[i], sc_a[i], sc_b[i]));
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      exp = pop_exp();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sc_done[%0d]: got %b want 1", i, done); end
      checks++; if (result !== exp) begin errors++; $display("FAIL sc_result[%0d]: got %h want %h", i, result, exp); end
      checks++; if (zero !== (exp == 32'h0)) begin errors++; $display("FAIL sc_zero[%0d]: got %b want %b", i, zero, exp == 32'h0); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL sc_done_pulse[%0d]: got %b want 0", i, done); end
    end
  endtask

  task automatic test_mul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int cyc, nbusy, stall_bad;
    bit seen;
    @(negedge clk);
    start = 1'b1; ALU_control = 3'b011; A = a; B = b;
    exp_q.push_back(model(3'b011, a, b));
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mul_stall_start: got %b want 1", stall); end
    @(posedge clk); #1 start = 1'b0; A = 32'h5A5A_5A5A; B = 32'hA5A5_A5A5;
    cyc = 0; nbusy = 0; stall_bad = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk); cyc++;
      if (done === 1'b1) seen = 1;
      else begin
        if (busy === 1'b1) nbusy++;
        if (stall !== busy) stall_bad++;
      end
    end
    exp = pop_exp();
    checks++; if (!seen || cyc != 33) begin errors++; $display("FAIL mul_latency: got %0d (seen=%0d) want 33", cyc, seen); end
    checks++; if (nbusy != 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 32", nbusy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_at_done: got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mul_stall_at_done: got %b want 0", stall); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL mul_stall_track: got %0d bad cycles want 0", stall_bad); end
    checks++; if (result !== exp) begin errors++; $display("FAIL mul_result: got %h want %h", result, exp); end
    checks++; if (zero !== (exp == 32'h0)) begin errors++; $display("FAIL mul_zero: got %b want %b", zero, exp == 32'h0); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] exp;
    int cyc;
    bit seen;
    @(negedge clk);
    start = 1'b1; ALU_control = 3'b011; A = 32'h0000_1234; B = 32'h0000_0010;
    exp_q.push_back(model(3'b011, 32'h0000_1234, 32'h0000_0010));
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk); cyc++;
      if (done === 1'b1) seen = 1;
      else if (cyc == 10) begin
        start = 1'b1; ALU_control = 3'b010; A = 32'h1; B = 32'h1;
      end else if (cyc == 11) start = 1'b0;
    end
    exp = pop_exp();
    checks++; if (!seen || cyc != 33) begin errors++; $display("FAIL swb_latency: got %0d (seen=%0d) want 33", cyc, seen); end
    checks++; if (result !== exp) begin errors++; $display("FAIL swb_result: got %h want %h", result, exp); end
    // Issue the follow-up add in the done cycle itself.
    start = 1'b1; ALU_control = 3'b010; A = 32'h1; B = 32'h1;
    exp_q.push_back(model(3'b010, 32'h1, 32'h1));
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    exp = pop_exp();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL swb_add_done: got %b want 1", done); end
    checks++; if (result !== exp) begin errors++; $display("FAIL swb_add_result: got %h want %h", result, exp); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    int ndone;
    @(negedge clk);
    start = 1'b1; ALU_control = 3'b011; A = 32'd9; B = 32'd9;
    exp_q.push_back(model(3'b011, 32'd9, 32'd9));
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rm_result: got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rm_zero: got %b want 1", zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_done: got %b want 0", done); end
    exp_q.delete();
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rm_no_done: got %0d active cycles want 0", ndone); end
    start = 1'b1; ALU_control = 3'b111; A = 32'hFFFF_0000; B = 32'h0000_1234;
    exp_q.push_back(model(3'b111, 32'hFFFF_0000, 32'h0000_1234));
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    exp = pop_exp();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rm_undef_done: got %b want 1", done); end
    checks++; if (result !== exp) begin errors++; $display("FAIL rm_undef_result: got %h want %h", result, exp); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rm_undef_zero: got %b want 1", zero); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    logic [31:0] a, b;
    logic [2:0]  op;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      op = sc_op[i]; a = $urandom; b = $urandom;
      start = 1'b1; ALU_control = op; A = a; B = b;
      exp_q.push_back(model(op, a, b));
      @(posedge clk); #1;
      if (i == 3) start = 1'b0;
      @(negedge clk);
      exp = pop_exp();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got %b want 1", i, done); end
      checks++; if (result !== exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, result, exp); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_end: got %b want 0", done); end
  endtask

  initial begin
    sc_op[0] = 3'b000; sc_a[0] = 32'hF0F0_F0F0; sc_b[0] = 32'hFF00_FF00;
    sc_op[1] = 3'b001; sc_a[1] = 32'h1234_0000; sc_b[1] = 32'h0000_5678;
    sc_op[2] = 3'b010; sc_a[2] = 32'hFFFF_FFFF; sc_b[2] = 32'h0000_0001;
    sc_op[3] = 3'b110; sc_a[3] = 32'h0000_0005; sc_b[3] = 32'h0000_0007;
    sc_op[4] = 3'b100; sc_a[4] = 32'hAAAA_AAAA; sc_b[4] = 32'h5555_5555;
    sc_op[5] = 3'b101; sc_a[5] = 32'h0000_0001; sc_b[5] = 32'h0000_0001;
    sc_op[6] = 3'b010; sc_a[6] = 32'h0000_0003; sc_b[6] = 32'h0000_0004;
    sc_op[7] = 3'b110; sc_a[7] = 32'h8000_0000; sc_b[7] = 32'h0000_0001;

    test_reset();
    test_single_cycle();
    test_mul(32'd7, 32'd6);
    test_mul(32'h0001_0000, 32'h0001_0000);
    test_mul(32'hFFFF_FFFF, 32'd3);
    test_mul(32'h1234_5679, 32'h0000_0000);
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
